// File: rtl/carfield_region_map_cfg.sv
// Runtime-programmable address region map: reg-bus rule storage, background
// pairwise overlap scan and a one-stage lowest-index lookup pipeline.
module carfield_region_map_cfg #(
   parameter int unsigned NumRegions = 16,
   parameter int unsigned AddrWidth  = 48,
   parameter int unsigned IdxWidth   = (NumRegions > 1) ? $clog2(NumRegions) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cfg_req_i,
   input  logic                 cfg_we_i,
   input  logic [15:0]          cfg_addr_i,
   input  logic [31:0]          cfg_wdata_i,
   output logic [31:0]          cfg_rdata_o,
   output logic                 cfg_ready_o,
   output logic                 cfg_error_o,
   input  logic                 lkp_valid_i,
   output logic                 lkp_ready_o,
   input  logic [AddrWidth-1:0] lkp_addr_i,
   output logic                 res_valid_o,
   input  logic                 res_ready_i,
   output logic                 res_hit_o,
   output logic [IdxWidth-1:0]  res_idx_o,
   output logic                 res_conflict_o,
   output logic                 scan_busy_o
);

   localparam int unsigned HiWidth    = AddrWidth - 32;
   localparam logic [13:0] StatusWord = 14'(NumRegions * 8);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t state_q, state_d;

   logic [AddrWidth-1:0] base_q [NumRegions];
   logic [AddrWidth-1:0] size_q [NumRegions];
   logic [NumRegions-1:0] en_q, lock_q;

   logic                ovl_q;
   logic [7:0]          idx_a_q, idx_b_q;
   logic                found_q;
   logic [IdxWidth-1:0] fa_q, fb_q, pi_q, pj_q;
   logic                pair_ovl, last_pair;

   logic [13:0]         word;
   logic [10:0]         region;
   logic [2:0]          sel;
   logic                in_region, is_status;
   logic [IdxWidth-1:0] ridx;
   logic                acc_err;
   logic [31:0]         rd_data;
   logic                rule_wr;

   logic                lk_hit;
   logic [IdxWidth-1:0] lk_idx;
   logic                lkp_fire;

   // ---------------------------------------------------------------- decode
   assign word      = cfg_addr_i[15:2];
   assign region    = word[13:3];
   assign sel       = word[2:0];
   assign in_region = 32'(region) < NumRegions;
   assign is_status = (word == StatusWord);
   assign ridx      = IdxWidth'(region);

   always_comb begin
      acc_err = 1'b0;
      rd_data = '0;
      if (in_region) begin
         if (sel > 3'd4) begin
            acc_err = 1'b1;
         end else if (cfg_we_i && lock_q[ridx]) begin
            acc_err = 1'b1;
         end else begin
            case (sel)
               3'd0:    rd_data = base_q[ridx][31:0];
               3'd1:    rd_data = 32'(base_q[ridx] >> 32);
               3'd2:    rd_data = size_q[ridx][31:0];
               3'd3:    rd_data = 32'(size_q[ridx] >> 32);
               default: rd_data = {30'd0, lock_q[ridx], en_q[ridx]};
            endcase
         end
      end else if (is_status) begin
         if (cfg_we_i) acc_err = 1'b1;
         else rd_data = {8'h00, idx_b_q, idx_a_q, 6'd0, ovl_q, scan_busy_o};
      end else begin
         acc_err = 1'b1;
      end
   end

   assign cfg_ready_o = 1'b1;
   assign cfg_error_o = cfg_req_i && acc_err;
   assign cfg_rdata_o = (cfg_req_i && !cfg_we_i && !acc_err) ? rd_data : '0;
   assign rule_wr     = cfg_req_i && cfg_we_i && in_region && !acc_err;

   // ------------------------------------------------------------ rule store
   // Lock is sticky without extra logic: writes to a locked region never land.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned r = 0; r < NumRegions; r++) begin
            base_q[r] <= '0;
            size_q[r] <= '0;
         end
         en_q   <= '0;
         lock_q <= '0;
      end else if (rule_wr) begin
         case (sel)
            3'd0:    base_q[ridx][31:0]           <= cfg_wdata_i;
            3'd1:    base_q[ridx][AddrWidth-1:32] <= cfg_wdata_i[HiWidth-1:0];
            3'd2:    size_q[ridx][31:0]           <= cfg_wdata_i;
            3'd3:    size_q[ridx][AddrWidth-1:32] <= cfg_wdata_i[HiWidth-1:0];
            default: begin
               en_q[ridx]   <= cfg_wdata_i[0];
               lock_q[ridx] <= cfg_wdata_i[1];
            end
         endcase
      end
   end

   // ------------------------------------------------------------ scan FSM
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (rule_wr) state_d = SCAN;
         SCAN:    if (!rule_wr && last_pair) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      scan_busy_o = (state_q == SCAN);
   end

   generate
      if (NumRegions > 1) begin : g_pair
         logic [AddrWidth:0] end_i, end_j;
         assign end_i = {1'b0, base_q[pi_q]} + {1'b0, size_q[pi_q]};
         assign end_j = {1'b0, base_q[pj_q]} + {1'b0, size_q[pj_q]};
         assign pair_ovl = en_q[pi_q] && en_q[pj_q] && (|size_q[pi_q]) && (|size_q[pj_q])
                           && ({1'b0, base_q[pi_q]} < end_j) && ({1'b0, base_q[pj_q]} < end_i);
         assign last_pair = (pi_q == IdxWidth'(NumRegions - 2)) && (pj_q == IdxWidth'(NumRegions - 1));
      end else begin : g_single
         assign pair_ovl  = 1'b0;
         assign last_pair = 1'b1;
      end
   endgenerate

   // Published STATUS only changes at scan completion; found_q/fa_q/fb_q
   // hold the in-progress result so a restart never disturbs it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pi_q    <= '0;
         pj_q    <= '0;
         found_q <= 1'b0;
         fa_q    <= '0;
         fb_q    <= '0;
         ovl_q   <= 1'b0;
         idx_a_q <= '0;
         idx_b_q <= '0;
      end else if (rule_wr) begin
         pi_q    <= '0;
         pj_q    <= IdxWidth'(1);
         found_q <= 1'b0;
         fa_q    <= '0;
         fb_q    <= '0;
      end else if (state_q == SCAN) begin
         if (pair_ovl && !found_q) begin
            found_q <= 1'b1;
            fa_q    <= pi_q;
            fb_q    <= pj_q;
         end
         if (last_pair) begin
            ovl_q <= found_q || pair_ovl;
            if (found_q) begin
               idx_a_q <= 8'(fa_q);
               idx_b_q <= 8'(fb_q);
            end else if (pair_ovl) begin
               idx_a_q <= 8'(pi_q);
               idx_b_q <= 8'(pj_q);
            end else begin
               idx_a_q <= '0;
               idx_b_q <= '0;
            end
         end else if (pj_q == IdxWidth'(NumRegions - 1)) begin
            pi_q <= pi_q + IdxWidth'(1);
            pj_q <= pi_q + IdxWidth'(2);
         end else begin
            pj_q <= pj_q + IdxWidth'(1);
         end
      end
   end

   // ------------------------------------------------------------ lookup
   always_comb begin
      lk_hit = 1'b0;
      lk_idx = '0;
      for (int unsigned r = 0; r < NumRegions; r++) begin
         if (!lk_hit && en_q[r] && (|size_q[r])
             && ({1'b0, lkp_addr_i} >= {1'b0, base_q[r]})
             && ({1'b0, lkp_addr_i} <  ({1'b0, base_q[r]} + {1'b0, size_q[r]}))) begin
            lk_hit = 1'b1;
            lk_idx = IdxWidth'(r);
         end
      end
   end

   assign lkp_ready_o = !res_valid_o || res_ready_i;
   assign lkp_fire    = lkp_valid_i && lkp_ready_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         res_valid_o    <= 1'b0;
         res_hit_o      <= 1'b0;
         res_idx_o      <= '0;
         res_conflict_o <= 1'b0;
      end else if (lkp_fire) begin
         res_valid_o    <= 1'b1;
         res_hit_o      <= lk_hit;
         res_idx_o      <= lk_idx;
         res_conflict_o <= ovl_q;
      end else if (res_ready_i) begin
         res_valid_o    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_carfield_region_map_cfg.sv
// Bench for carfield_region_map_cfg: config vector table, directed multi-cycle
// sequences and randomized rules/lookups against an arithmetic reference model.
module tb_carfield_region_map_cfg;

   localparam int N  = 16;
   localparam int AW = 48;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_req, cfg_we;
   logic [15:0]   cfg_addr;
   logic [31:0]   cfg_wdata, cfg_rdata;
   logic          cfg_ready, cfg_error;
   logic          lkp_valid, lkp_ready;
   logic [AW-1:0] lkp_addr;
   logic          res_valid, res_ready, res_hit, res_conflict, scan_busy;
   logic [IW-1:0] res_idx;

   carfield_region_map_cfg #(.NumRegions(N), .AddrWidth(AW)) dut (
      .clk_i(clk), .rst_i(rst),
      .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
      .cfg_wdata_i(cfg_wdata), .cfg_rdata_o(cfg_rdata), .cfg_ready_o(cfg_ready),
      .cfg_error_o(cfg_error),
      .lkp_valid_i(lkp_valid), .lkp_ready_o(lkp_ready), .lkp_addr_i(lkp_addr),
      .res_valid_o(res_valid), .res_ready_i(res_ready), .res_hit_o(res_hit),
      .res_idx_o(res_idx), .res_conflict_o(res_conflict), .scan_busy_o(scan_busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [63:0] m_base [N];
   logic [63:0] m_size [N];
   bit          m_en   [N];
   bit          m_lock [N];

   typedef struct {
      string       name;
      bit          we;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      bit          err;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic bit model_err(input bit we, input int unsigned addr);
      int unsigned r, s;
      r = addr / 32;
      s = (addr % 32) / 4;
      if (r < N) return (s > 4) || (we && m_lock[r]);
      if (addr == N * 32) return we;
      return 1'b1;
   endfunction

   function automatic void model_write(input int unsigned addr, input logic [31:0] d);
      int unsigned r, s;
      r = addr / 32;
      s = (addr % 32) / 4;
      case (s)
         0: m_base[r][31:0]    = d;
         1: m_base[r][AW-1:32] = d[AW-33:0];
         2: m_size[r][31:0]    = d;
         3: m_size[r][AW-1:32] = d[AW-33:0];
         default: begin
            m_en[r]   = d[0];
            m_lock[r] = m_lock[r] | d[1];
         end
      endcase
   endfunction

   function automatic logic [31:0] model_read(input int unsigned addr);
      int unsigned r, s;
      r = addr / 32;
      s = (addr % 32) / 4;
      case (s)
         0: return m_base[r][31:0];
         1: return 32'(m_base[r] >> 32);
         2: return m_size[r][31:0];
         3: return 32'(m_size[r] >> 32);
         default: return {30'd0, m_lock[r], m_en[r]};
      endcase
   endfunction

   function automatic void model_lookup(input logic [63:0] a, output bit hit, output int idx);
      hit = 0;
      idx = 0;
      for (int r = 0; r < N; r++)
         if (!hit && m_en[r] && m_size[r] != 0 && a >= m_base[r] && a < m_base[r] + m_size[r]) begin
            hit = 1;
            idx = r;
         end
   endfunction

   function automatic void model_scan(output bit ovl, output int ia, output int ib);
      ovl = 0; ia = 0; ib = 0;
      for (int i = 0; i < N; i++)
         for (int j = i + 1; j < N; j++)
            if (!ovl && m_en[i] && m_en[j] && m_size[i] != 0 && m_size[j] != 0 &&
                m_base[i] < m_base[j] + m_size[j] && m_base[j] < m_base[i] + m_size[i]) begin
               ovl = 1; ia = i; ib = j;
            end
   endfunction

   task automatic cfg_access(input bit we, input logic [15:0] addr, input logic [31:0] wd,
                             output logic [31:0] rd, output logic err);
      @(negedge clk);
      cfg_req = 1; cfg_we = we; cfg_addr = addr; cfg_wdata = wd;
      #1;
      rd  = cfg_rdata;
      err = cfg_error;
      @(posedge clk);
      #1;
      cfg_req = 0; cfg_we = 0;
   endtask

   task automatic cfg_wr(input string name, input logic [15:0] addr, input logic [31:0] wd);
      logic [31:0] rd;
      logic        err;
      bit          exp;
      exp = model_err(1'b1, addr);
      cfg_access(1'b1, addr, wd, rd, err);
      chk({name, "_err"}, 64'(err), 64'(exp));
      if (!exp) model_write(addr, wd);
   endtask

   task automatic cfg_rd(input string name, input logic [15:0] addr, input logic [31:0] exp);
      logic [31:0] rd;
      logic        err;
      cfg_access(1'b0, addr, 32'h0, rd, err);
      chk({name, "_rdata"}, 64'(rd), 64'(exp));
      chk({name, "_err"}, 64'(err), 64'd0);
   endtask

   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (cycles < 5000) begin
         @(negedge clk);
         if (!scan_busy) break;
         cycles++;
      end
      if (cycles >= 5000) chk("scan_timeout", 64'(cycles), 64'd0);
   endtask

   task automatic lookup_chk(input string name, input logic [63:0] a, input bit conf);
      bit hit;
      int idx, n;
      model_lookup(a, hit, idx);
      @(negedge clk);
      lkp_valid = 1; lkp_addr = AW'(a); res_ready = 1;
      n = 0;
      while (!lkp_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk({name, "_ready_timeout"}, 64'(n), 64'd0);
      @(posedge clk);
      #1;
      lkp_valid = 0;
      chk({name, "_valid"}, 64'(res_valid), 64'd1);
      chk({name, "_hit"}, 64'(res_hit), 64'(hit));
      chk({name, "_idx"}, 64'(res_idx), 64'(idx));
      chk({name, "_conflict"}, 64'(res_conflict), 64'(conf));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          cyc, ia, ib, ex_idx;
      bit          ovl, ex_hit;
      logic [31:0] rd;
      logic        err;
      logic [63:0] bp [5];

      rst = 1; cfg_req = 0; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0;
      lkp_valid = 0; lkp_addr = '0; res_ready = 1;
      for (int r = 0; r < N; r++) begin
         m_base[r] = '0; m_size[r] = '0; m_en[r] = 0; m_lock[r] = 0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 0;

      // reset state
      @(negedge clk);
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chk("rst_scan_busy", 64'(scan_busy), 64'd0);
      chk("rst_res_hit", 64'(res_hit), 64'd0);
      chk("rst_res_idx", 64'(res_idx), 64'd0);
      chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);

      // config port vector table
      vecs.push_back('{"r0_base_lo_rst", 0, 16'h0000, 32'h0, 32'h0, 0});
      vecs.push_back('{"r15_ctrl_rst",   0, 16'h01F0, 32'h0, 32'h0, 0});
      vecs.push_back('{"status_rst",     0, 16'h0200, 32'h0, 32'h0, 0});
      vecs.push_back('{"hole_rd",        0, 16'h0014, 32'h0, 32'h0, 1});
      vecs.push_back('{"beyond_rd",      0, 16'h0204, 32'h0, 32'h0, 1});
      vecs.push_back('{"status_wr",      1, 16'h0200, 32'hFFFF_FFFF, 32'h0, 1});
      vecs.push_back('{"r1_hi_wr",       1, 16'h0024, 32'hFFFF_FFFF, 32'h0, 0});
      vecs.push_back('{"r1_hi_rd",       0, 16'h0024, 32'h0, 32'h0000_FFFF, 0});
      vecs.push_back('{"r1_hi_clr",      1, 16'h0024, 32'h0, 32'h0, 0});
      vecs.push_back('{"r1_ctrl_wr",     1, 16'h0030, 32'hFFFF_FFFC, 32'h0, 0});
      vecs.push_back('{"r1_ctrl_rd",     0, 16'h0030, 32'h0, 32'h0, 0});
      vecs.push_back('{"hole_wr",        1, 16'h001C, 32'h1, 32'h0, 1});
      vecs.push_back('{"r0_base_wr",     1, 16'h0000, 32'h7800_0000, 32'h0, 0});
      vecs.push_back('{"r0_size_wr",     1, 16'h0008, 32'h0020_0000, 32'h0, 0});
      vecs.push_back('{"r0_ctrl_wr",     1, 16'h0010, 32'h0000_0001, 32'h0, 0});
      vecs.push_back('{"r0_ctrl_rd",     0, 16'h0010, 32'h0, 32'h0000_0001, 0});
      vecs.push_back('{"r0_base_rd",     0, 16'h0000, 32'h0, 32'h7800_0000, 0});
      foreach (vecs[k]) begin
         cfg_access(vecs[k].we, vecs[k].addr, vecs[k].wdata, rd, err);
         chk({vecs[k].name, "_err"}, 64'(err), 64'(vecs[k].err));
         if (!vecs[k].we) chk({vecs[k].name, "_rdata"}, 64'(rd), 64'(vecs[k].rdata));
         else if (!vecs[k].err) model_write(vecs[k].addr, vecs[k].wdata);
      end
      wait_idle(cyc);

      // single rule, edges of its window
      lookup_chk("r0_last", 64'h7820_0000 - 1, 1'b0);
      lookup_chk("r0_end",  64'h7820_0000, 1'b0);

      // overlapping rule1 and scan length
      cfg_wr("r1_base", 16'h0020, 32'h7810_0000);
      cfg_wr("r1_size", 16'h0028, 32'h0020_0000);
      cfg_wr("r1_ctrl", 16'h0030, 32'h1);
      wait_idle(cyc);
      chk("scan_len", 64'(cyc), 64'd120);
      cfg_rd("status_ovl", 16'h0200, 32'h0001_0002);
      lookup_chk("ovl_lookup", 64'h7810_0000, 1'b1);

      // locked rule rejects writes, no scan
      cfg_wr("r2_lock", 16'h0050, 32'h3);
      wait_idle(cyc);
      cfg_wr("r2_locked_base", 16'h0040, 32'h0000_1234);
      @(negedge clk);
      chk("locked_no_scan", 64'(scan_busy), 64'd0);
      cfg_rd("r2_base_unchanged", 16'h0040, 32'h0);
      cfg_wr("r2_unlock_try", 16'h0050, 32'h0);
      cfg_rd("r2_ctrl_sticky", 16'h0050, 32'h3);

      // top-of-space rule: base+size exceeds 2^48
      cfg_wr("r3_base_lo", 16'h0060, 32'hFFFF_F000);
      cfg_wr("r3_base_hi", 16'h0064, 32'h0000_FFFF);
      cfg_wr("r3_size",    16'h0068, 32'h0000_2000);
      cfg_wr("r3_ctrl",    16'h0070, 32'h1);
      wait_idle(cyc);
      lookup_chk("top_hit",  64'hFFFF_FFFF_FFFF, 1'b1);
      lookup_chk("zero_miss", 64'h0, 1'b1);

      // mid-scan restart keeps old result and resets duration
      cfg_wr("restart_a", 16'h0070, 32'h1);
      repeat (50) @(negedge clk);
      chk("mid_busy", 64'(scan_busy), 64'd1);
      cfg_rd("mid_status", 16'h0200, 32'h0001_0003);
      cfg_wr("restart_b", 16'h0070, 32'h1);
      wait_idle(cyc);
      chk("restart_len", 64'(cyc), 64'd120);

      // backpressure then back-to-back throughput
      bp[0] = 64'h7800_0010; bp[1] = 64'h7818_0000; bp[2] = 64'h7825_0000;
      bp[3] = 64'hFFFF_FFFF_F800; bp[4] = 64'h5;
      @(negedge clk);
      lkp_valid = 1; lkp_addr = AW'(bp[0]); res_ready = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         model_lookup(bp[0], ex_hit, ex_idx);
         chk("bp_valid", 64'(res_valid), 64'd1);
         chk("bp_ready_low", 64'(lkp_ready), 64'd0);
         chk("bp_hold_hit", 64'(res_hit), 64'(ex_hit));
         chk("bp_hold_idx", 64'(res_idx), 64'(ex_idx));
         lkp_addr = AW'(bp[1]);
      end
      res_ready = 1;
      for (int k = 1; k < 5; k++) begin
         @(negedge clk);
         model_lookup(bp[k], ex_hit, ex_idx);
         chk("b2b_valid", 64'(res_valid), 64'd1);
         chk("b2b_hit", 64'(res_hit), 64'(ex_hit));
         chk("b2b_idx", 64'(res_idx), 64'(ex_idx));
         if (k < 4) lkp_addr = AW'(bp[k + 1]);
         else lkp_valid = 0;
      end
      @(negedge clk);
      chk("b2b_drain", 64'(res_valid), 64'd0);

      // randomized rules in a shared window versus the model
      cfg_wr("r1_disable", 16'h0030, 32'h0);
      wait_idle(cyc);
      for (int round = 0; round < 6; round++) begin
         for (int r = 4; r < 8; r++) begin
            cfg_wr("rnd_base", 16'(r * 32 + 0), 32'h1000_0000 + 32'($urandom_range(0, 15)) * 32'h800);
            cfg_wr("rnd_size", 16'(r * 32 + 8), 32'($urandom_range(0, 3)) * 32'h1000);
            cfg_wr("rnd_ctrl", 16'(r * 32 + 16), ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1)));
         end
         cfg_rd("rnd_ctrl_rd", 16'(5 * 32 + 16), model_read(5 * 32 + 16));
         cfg_rd("rnd_size_rd", 16'(6 * 32 + 8), model_read(6 * 32 + 8));
         wait_idle(cyc);
         model_scan(ovl, ia, ib);
         cfg_access(1'b0, 16'h0200, 32'h0, rd, err);
         chk("rnd_status_ovl", 64'(rd[1:0]), 64'({ovl, 1'b0}));
         if (ovl) chk("rnd_status_pair", 64'(rd[23:8]), 64'({8'(ib), 8'(ia)}));
         for (int q = 0; q < 8; q++)
            lookup_chk("rnd_lookup", 64'h1000_0000 + 64'($urandom_range(0, 32'hA000)), ovl);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
